// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store pipeline stage.
package lsu_pkg;

  // Upstream op codes; any code not listed here passes straight through.
  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLb  = 4'h1;
  localparam logic [3:0] OpLh  = 4'h2;
  localparam logic [3:0] OpLw  = 4'h3;
  localparam logic [3:0] OpLd  = 4'h4;
  localparam logic [3:0] OpLbu = 4'h5;
  localparam logic [3:0] OpLhu = 4'h6;
  localparam logic [3:0] OpLwu = 4'h7;
  localparam logic [3:0] OpSb  = 4'h8;
  localparam logic [3:0] OpSh  = 4'h9;
  localparam logic [3:0] OpSw  = 4'hA;
  localparam logic [3:0] OpSd  = 4'hB;

  // Exception causes reported on exc_cause_o.
  localparam logic [3:0] CauseLoadMisaligned  = 4'd4;
  localparam logic [3:0] CauseLoadFault       = 4'd5;
  localparam logic [3:0] CauseStoreMisaligned = 4'd6;
  localparam logic [3:0] CauseStoreFault      = 4'd7;

  typedef enum logic {
    StIdle,
    StBus
  } lsu_state_e;

  typedef enum logic [1:0] {
    SizeB,
    SizeH,
    SizeW,
    SizeD
  } lsu_size_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / data replication, load lane extract and extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NB  = XLEN / 8,
  localparam int unsigned OW  = $clog2(NB)
) (
  input  lsu_size_e         st_size_i,
  input  logic [OW-1:0]     st_off_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic [NB-1:0]     st_be_o,
  output logic [XLEN-1:0]   st_data_o,
  input  lsu_size_e         ld_size_i,
  input  logic              ld_unsigned_i,
  input  logic [OW-1:0]     ld_off_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [7:0]      size_mask;
  logic [XLEN-1:0] ld_shifted;

  // Store side: byte-enable mask at the offset, data replicated into every lane.
  always_comb begin
    st_data_o = '0;
    case (st_size_i)
      SizeB:   size_mask = 8'h01;
      SizeH:   size_mask = 8'h03;
      SizeW:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    st_be_o = NB'(size_mask << st_off_i);
    for (int i = 0; i < int'(NB); i++) begin
      case (st_size_i)
        SizeB:   st_data_o[8*i +: 8] = st_data_i[7:0];
        SizeH:   st_data_o[8*i +: 8] = st_data_i[8*(i%2) +: 8];
        SizeW:   st_data_o[8*i +: 8] = st_data_i[8*(i%4) +: 8];
        default: st_data_o[8*i +: 8] = st_data_i[8*i +: 8];
      endcase
    end
  end

  // Load side: shift the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      SizeB: begin
        if (ld_unsigned_i) ld_data_o = XLEN'(ld_shifted[7:0]);
        else               ld_data_o = XLEN'($signed(ld_shifted[7:0]));
      end
      SizeH: begin
        if (ld_unsigned_i) ld_data_o = XLEN'(ld_shifted[15:0]);
        else               ld_data_o = XLEN'($signed(ld_shifted[15:0]));
      end
      SizeW: begin
        if (ld_unsigned_i) ld_data_o = XLEN'(ld_shifted[31:0]);
        else               ld_data_o = XLEN'($signed(ld_shifted[31:0]));
      end
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store stage: issues one bus access, stalls upstream until it completes.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [XLEN-1:0]       mem_data_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [XLEN-1:0]       reg_wdata_i,
  output logic                  stall_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [XLEN/8-1:0]     bus_be_o,
  output logic [XLEN-1:0]       bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_err_i,
  input  logic [XLEN-1:0]       bus_rdata_i,
  output logic                  valid_o,
  output logic [4:0]            reg_waddr_o,
  output logic                  reg_we_o,
  output logic [XLEN-1:0]       reg_wdata_o,
  output logic                  exc_o,
  output logic [3:0]            exc_cause_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  lsu_state_e            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  exc_q, exc_d;
  logic [3:0]            cause_q, cause_d;
  logic [4:0]            waddr_q, waddr_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]         bus_be_q, bus_be_d;
  logic [XLEN-1:0]       bus_wdata_q, bus_wdata_d;
  lsu_size_e             ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [OW-1:0]         ld_off_q, ld_off_d;
  logic                  is_ld_q, is_ld_d;
  logic                  pend_we_q, pend_we_d;

  logic                  is_ld, is_st, is_uns, misaligned;
  lsu_size_e             size;
  logic [OW-1:0]         off, align_mask;
  logic [NB-1:0]         st_be;
  logic [XLEN-1:0]       st_data, ld_data;

  assign off = mem_addr_i[OW-1:0];

  // Op decode; 64-bit-only ops fall through as plain writebacks on a 32-bit core.
  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_uns = 1'b0;
    size   = SizeB;
    case (mem_op_i)
      OpLb:  is_ld = 1'b1;
      OpLh:  begin is_ld = 1'b1; size = SizeH; end
      OpLw:  begin is_ld = 1'b1; size = SizeW; end
      OpLd:  if (XLEN == 64) begin is_ld = 1'b1; size = SizeD; end
      OpLbu: begin is_ld = 1'b1; is_uns = 1'b1; end
      OpLhu: begin is_ld = 1'b1; is_uns = 1'b1; size = SizeH; end
      OpLwu: if (XLEN == 64) begin is_ld = 1'b1; is_uns = 1'b1; size = SizeW; end
      OpSb:  is_st = 1'b1;
      OpSh:  begin is_st = 1'b1; size = SizeH; end
      OpSw:  begin is_st = 1'b1; size = SizeW; end
      OpSd:  if (XLEN == 64) begin is_st = 1'b1; size = SizeD; end
      default: ;
    endcase
    align_mask = OW'((8'd1 << size) - 8'd1);
    misaligned = |(off & align_mask);
  end

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .st_size_i     (size),
    .st_off_i      (off),
    .st_data_i     (mem_data_i),
    .st_be_o       (st_be),
    .st_data_o     (st_data),
    .ld_size_i     (ld_size_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_off_i      (ld_off_q),
    .ld_rdata_i    (bus_rdata_i),
    .ld_data_o     (ld_data)
  );

  // Next state: accept in IDLE, wait for ack/error/timeout in BUS.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    exc_d       = 1'b0;
    cause_d     = '0;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    ld_off_d    = ld_off_q;
    is_ld_d     = is_ld_q;
    pend_we_d   = pend_we_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          waddr_d = reg_waddr_i;
          if (is_ld || is_st) begin
            if (misaligned) begin
              valid_d = 1'b1;
              exc_d   = 1'b1;
              wdata_d = '0;
              cause_d = is_ld ? CauseLoadMisaligned : CauseStoreMisaligned;
            end else begin
              state_d     = StBus;
              cnt_d       = '0;
              bus_we_d    = is_st;
              bus_addr_d  = {mem_addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
              bus_be_d    = st_be;
              bus_wdata_d = st_data;
              ld_size_d   = size;
              ld_uns_d    = is_uns;
              ld_off_d    = off;
              is_ld_d     = is_ld;
              pend_we_d   = is_ld & reg_we_i;
            end
          end else begin
            valid_d = 1'b1;
            we_d    = reg_we_i;
            wdata_d = reg_wdata_i;
          end
        end
      end
      StBus: begin
        if (bus_ack_i) begin
          state_d = StIdle;
          valid_d = 1'b1;
          if (bus_err_i) begin
            exc_d   = 1'b1;
            wdata_d = '0;
            cause_d = is_ld_q ? CauseLoadFault : CauseStoreFault;
          end else begin
            we_d    = pend_we_q;
            wdata_d = is_ld_q ? ld_data : '0;
          end
        end else if (TIMEOUT_CYCLES != 0 && (cnt_q + 32'd1) == TIMEOUT_CYCLES) begin
          // No response in time: abandon the access and report it as an access fault.
          state_d = StIdle;
          valid_d = 1'b1;
          exc_d   = 1'b1;
          wdata_d = '0;
          cause_d = is_ld_q ? CauseLoadFault : CauseStoreFault;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      exc_q       <= 1'b0;
      cause_q     <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      ld_size_q   <= SizeB;
      ld_uns_q    <= 1'b0;
      ld_off_q    <= '0;
      is_ld_q     <= 1'b0;
      pend_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      ld_off_q    <= ld_off_d;
      is_ld_q     <= is_ld_d;
      pend_we_q   <= pend_we_d;
    end
  end

  assign stall_o     = (state_q == StBus);
  assign bus_req_o   = (state_q == StBus);
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign valid_o     = valid_q;
  assign reg_waddr_o = waddr_q;
  assign reg_we_o    = we_q;
  assign reg_wdata_o = wdata_q;
  assign exc_o       = exc_q;
  assign exc_cause_o = cause_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: a 32-bit instance (short timeout) and a 64-bit instance.
module tb_lsu_pipe;

  typedef struct {
    logic [4:0]  wa;
    logic        we;
    logic [63:0] wd;
    logic        chk_wd;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        valid, we, stall, bus_req, bus_we, ack, err, valid_o, we_o, exc;
  logic [3:0]  op, be, cause;
  logic [31:0] addr, data, wd, bus_addr, bus_wdata, rdata, wdata_o;
  logic [4:0]  wa, waddr_o;

  // 64-bit instance signals
  logic        w_valid, w_we, w_stall, w_bus_req, w_bus_we, w_ack, w_err, w_valid_o, w_we_o, w_exc;
  logic [3:0]  w_op, w_cause;
  logic [7:0]  w_be;
  logic [31:0] w_addr, w_bus_addr;
  logic [63:0] w_data, w_wd, w_bus_wdata, w_rdata, w_wdata_o;
  logic [4:0]  w_wa, w_waddr_o;

  lsu_pipe #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .mem_op_i(op), .mem_addr_i(addr),
    .mem_data_i(data), .reg_waddr_i(wa), .reg_we_i(we), .reg_wdata_i(wd), .stall_o(stall),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(ack), .bus_err_i(err), .bus_rdata_i(rdata),
    .valid_o(valid_o), .reg_waddr_o(waddr_o), .reg_we_o(we_o), .reg_wdata_o(wdata_o),
    .exc_o(exc), .exc_cause_o(cause)
  );

  lsu_pipe #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(w_valid), .mem_op_i(w_op), .mem_addr_i(w_addr),
    .mem_data_i(w_data), .reg_waddr_i(w_wa), .reg_we_i(w_we), .reg_wdata_i(w_wd),
    .stall_o(w_stall), .bus_req_o(w_bus_req), .bus_we_o(w_bus_we), .bus_addr_o(w_bus_addr),
    .bus_be_o(w_be), .bus_wdata_o(w_bus_wdata), .bus_ack_i(w_ack), .bus_err_i(w_err),
    .bus_rdata_i(w_rdata), .valid_o(w_valid_o), .reg_waddr_o(w_waddr_o), .reg_we_o(w_we_o),
    .reg_wdata_o(w_wdata_o), .exc_o(w_exc), .exc_cause_o(w_cause)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input exp_t e, input logic [4:0] a, input logic w,
                              input logic [63:0] d, input logic x, input logic [3:0] c);
    chk("wb_waddr", {59'd0, a}, {59'd0, e.wa});
    chk("wb_we", {63'd0, w}, {63'd0, e.we});
    chk("wb_exc", {63'd0, x}, {63'd0, e.exc});
    if (e.chk_wd) chk("wb_wdata", d, e.wd);
    if (e.exc) chk("wb_cause", {60'd0, c}, {60'd0, e.cause});
  endtask

  // Scoreboard: every valid_o pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (valid_o) begin
      if (q32.size() == 0) chk("spurious_valid32", {63'd0, valid_o}, 64'd0);
      else check_result(q32.pop_front(), waddr_o, we_o, {32'd0, wdata_o}, exc, cause);
    end
    if (w_valid_o) begin
      if (q64.size() == 0) chk("spurious_valid64", {63'd0, w_valid_o}, 64'd0);
      else check_result(q64.pop_front(), w_waddr_o, w_we_o, w_wdata_o, w_exc, w_cause);
    end
  end

  task automatic push(input bit w64, input logic [4:0] a, input logic w, input logic [63:0] d,
                      input logic cd, input logic x, input logic [3:0] c);
    exp_t e;
    e.wa = a; e.we = w; e.wd = d; e.chk_wd = cd; e.exc = x; e.cause = c;
    if (w64) q64.push_back(e);
    else     q32.push_back(e);
  endtask

  // Present one op for one cycle; returns at the negedge after it was accepted.
  task automatic issue(input bit w64, input logic [3:0] o, input logic [31:0] a,
                       input logic [63:0] d, input logic [4:0] r, input logic w,
                       input logic [63:0] v);
    @(negedge clk);
    if (w64) begin
      w_valid = 1'b1; w_op = o; w_addr = a; w_data = d; w_wa = r; w_we = w; w_wd = v;
    end else begin
      valid = 1'b1; op = o; addr = a; data = d[31:0]; wa = r; we = w; wd = v[31:0];
    end
    @(negedge clk);
    valid = 1'b0;
    w_valid = 1'b0;
  endtask

  // Hold off ack for 'waits' BUS cycles, then ack; counts stall cycles and valid_o pulses.
  task automatic run_bus(input bit w64, input int waits, input logic [63:0] rd, input logic e,
                         output int sc, output int vc);
    sc = 0;
    vc = 0;
    for (int i = 0; i < waits; i++) begin
      sc += (w64 ? w_stall : stall) ? 1 : 0;
      @(negedge clk);
    end
    sc += (w64 ? w_stall : stall) ? 1 : 0;
    if (w64) begin w_ack = 1'b1; w_rdata = rd; w_err = e; end
    else     begin ack = 1'b1; rdata = rd[31:0]; err = e; end
    @(negedge clk);
    ack = 1'b0; err = 1'b0; w_ack = 1'b0; w_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vc += (w64 ? w_valid_o : valid_o) ? 1 : 0;
      if (i < 2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, vc, n;
    valid = 0; op = 0; addr = 0; data = 0; wa = 0; we = 0; wd = 0; ack = 0; err = 0; rdata = 0;
    w_valid = 0; w_op = 0; w_addr = 0; w_data = 0; w_wa = 0; w_we = 0; w_wd = 0;
    w_ack = 0; w_err = 0; w_rdata = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_exc", {63'd0, exc}, 64'd0);
    chk("rst_bus_addr", {32'd0, bus_addr}, 64'd0);
    repeat (2) @(negedge clk);

    // Op presented together with reset release is taken on the very next edge.
    rst_n = 1'b1;
    push(0, 5'd1, 1'b1, 64'h1111_2222, 1'b1, 1'b0, 4'd0);
    valid = 1'b1; op = 4'hF; wa = 5'd1; we = 1'b1; wd = 32'h1111_2222;
    @(negedge clk);
    valid = 1'b0;
    chk("first_op_valid", {63'd0, valid_o}, 64'd1);

    // LB sign-extended, two wait states.
    push(0, 5'd5, 1'b1, 64'hFFFF_FF80, 1'b1, 1'b0, 4'd0);
    issue(0, 4'h1, 32'h1003, 64'd0, 5'd5, 1'b1, 64'd0);
    run_bus(0, 2, 64'h80FF_FF00, 1'b0, sc, vc);
    chk("lb_stall_cycles", sc, 3);
    chk("lb_valid_pulses", vc, 1);

    // Pass-through op.
    push(0, 5'd7, 1'b1, 64'h1234_5678, 1'b1, 1'b0, 4'd0);
    issue(0, 4'hF, 32'h0, 64'd0, 5'd7, 1'b1, 64'h1234_5678);

    // LD is not a memory op on a 32-bit core.
    push(0, 5'd8, 1'b1, 64'hCAFE_F00D, 1'b1, 1'b0, 4'd0);
    issue(0, 4'h4, 32'h100, 64'd0, 5'd8, 1'b1, 64'hCAFE_F00D);
    chk("ld32_no_req", {63'd0, bus_req}, 64'd0);

    // SH: lane enables and replicated data, no writeback.
    push(0, 5'd3, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    issue(0, 4'h9, 32'h2002, 64'hABCD, 5'd3, 1'b1, 64'd0);
    chk("sh_req", {63'd0, bus_req}, 64'd1);
    chk("sh_we", {63'd0, bus_we}, 64'd1);
    chk("sh_addr", {32'd0, bus_addr}, 64'h2000);
    chk("sh_be", {60'd0, be}, 64'hC);
    chk("sh_wdata", {32'd0, bus_wdata}, 64'hABCD_ABCD);
    run_bus(0, 0, 64'd0, 1'b0, sc, vc);

    // Misaligned LW and SW: no bus request, exception pulse.
    push(0, 5'd4, 1'b0, 64'd0, 1'b0, 1'b1, 4'd4);
    issue(0, 4'h3, 32'h3001, 64'd0, 5'd4, 1'b1, 64'd0);
    chk("lw_mis_no_req", {63'd0, bus_req}, 64'd0);
    @(negedge clk);
    chk("lw_mis_pulse_end", {63'd0, valid_o}, 64'd0);
    push(0, 5'd6, 1'b0, 64'd0, 1'b0, 1'b1, 4'd6);
    issue(0, 4'hA, 32'h4002, 64'h55, 5'd6, 1'b1, 64'd0);
    chk("sw_mis_no_req", {63'd0, bus_req}, 64'd0);

    // Halfword / byte extension variants.
    push(0, 5'd9, 1'b1, 64'hFFFF_8001, 1'b1, 1'b0, 4'd0);
    issue(0, 4'h2, 32'h5002, 64'd0, 5'd9, 1'b1, 64'd0);
    run_bus(0, 1, 64'h8001_0000, 1'b0, sc, vc);
    push(0, 5'd10, 1'b1, 64'h0000_8001, 1'b1, 1'b0, 4'd0);
    issue(0, 4'h6, 32'h5002, 64'd0, 5'd10, 1'b1, 64'd0);
    run_bus(0, 0, 64'h8001_0000, 1'b0, sc, vc);
    push(0, 5'd11, 1'b1, 64'h0000_00F7, 1'b1, 1'b0, 4'd0);
    issue(0, 4'h5, 32'h6001, 64'd0, 5'd11, 1'b1, 64'd0);
    run_bus(0, 0, 64'h0000_F700, 1'b0, sc, vc);

    // Bus errors on load and store.
    push(0, 5'd12, 1'b0, 64'd0, 1'b0, 1'b1, 4'd5);
    issue(0, 4'h3, 32'h7000, 64'd0, 5'd12, 1'b1, 64'd0);
    run_bus(0, 0, 64'h1234, 1'b1, sc, vc);
    push(0, 5'd13, 1'b0, 64'd0, 1'b0, 1'b1, 4'd7);
    issue(0, 4'h8, 32'h8001, 64'h5A, 5'd13, 1'b1, 64'd0);
    chk("sb_be", {60'd0, be}, 64'h2);
    chk("sb_wdata", {32'd0, bus_wdata}, 64'h5A5A_5A5A);
    run_bus(0, 0, 64'd0, 1'b1, sc, vc);

    // Timeout after 4 BUS cycles.
    push(0, 5'd14, 1'b0, 64'd0, 1'b0, 1'b1, 4'd5);
    issue(0, 4'h3, 32'h9000, 64'd0, 5'd14, 1'b1, 64'd0);
    n = 0;
    for (int i = 0; i < 20 && bus_req; i++) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 4);

    // Ack while idle is ignored.
    @(negedge clk);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_ignored", {63'd0, valid_o}, 64'd0);

    // Reset in the middle of a transaction.
    issue(0, 4'h3, 32'hA000, 64'd0, 5'd15, 1'b1, 64'd0);
    chk("pre_rst_req", {63'd0, bus_req}, 64'd1);
    #2;
    rst_n = 1'b0;
    ack = 1'b1; rdata = 32'h0BAD_0BAD;
    #1;
    chk("mid_rst_req", {63'd0, bus_req}, 64'd0);
    chk("mid_rst_stall", {63'd0, stall}, 64'd0);
    chk("mid_rst_valid", {63'd0, valid_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack = 1'b0;
    vc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vc += valid_o ? 1 : 0;
    end
    chk("post_rst_no_completion", vc, 0);

    // 64-bit instance: LWU lane select, LW sign, LD, SD, SW replicate, misaligned LD.
    push(1, 5'd1, 1'b1, 64'h0000_0000_8000_0001, 1'b1, 1'b0, 4'd0);
    issue(1, 4'h7, 32'h14, 64'd0, 5'd1, 1'b1, 64'd0);
    chk("lwu64_addr", {32'd0, w_bus_addr}, 64'h10);
    chk("lwu64_be", {56'd0, w_be}, 64'hF0);
    run_bus(1, 0, 64'h8000_0001_1234_5678, 1'b0, sc, vc);
    push(1, 5'd2, 1'b1, 64'h0000_0000_1234_5678, 1'b1, 1'b0, 4'd0);
    issue(1, 4'h7, 32'h10, 64'd0, 5'd2, 1'b1, 64'd0);
    run_bus(1, 0, 64'h8000_0001_1234_5678, 1'b0, sc, vc);
    push(1, 5'd3, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0, 4'd0);
    issue(1, 4'h3, 32'h14, 64'd0, 5'd3, 1'b1, 64'd0);
    run_bus(1, 1, 64'h8000_0001_1234_5678, 1'b0, sc, vc);
    push(1, 5'd4, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 4'd0);
    issue(1, 4'h4, 32'h18, 64'd0, 5'd4, 1'b1, 64'd0);
    chk("ld64_addr", {32'd0, w_bus_addr}, 64'h18);
    run_bus(1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, sc, vc);
    push(1, 5'd5, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    issue(1, 4'hB, 32'h8, 64'hDEAD_BEEF_CAFE_F00D, 5'd5, 1'b1, 64'd0);
    chk("sd64_be", {56'd0, w_be}, 64'hFF);
    chk("sd64_wdata", w_bus_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    run_bus(1, 0, 64'd0, 1'b0, sc, vc);
    push(1, 5'd6, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    issue(1, 4'hA, 32'h4, 64'h1122_3344, 5'd6, 1'b1, 64'd0);
    chk("sw64_be", {56'd0, w_be}, 64'hF0);
    chk("sw64_wdata", w_bus_wdata, 64'h1122_3344_1122_3344);
    run_bus(1, 0, 64'd0, 1'b0, sc, vc);
    push(1, 5'd7, 1'b0, 64'd0, 1'b0, 1'b1, 4'd4);
    issue(1, 4'h4, 32'h1C, 64'd0, 5'd7, 1'b1, 64'd0);
    chk("ld64_mis_no_req", {63'd0, w_bus_req}, 64'd0);

    repeat (3) @(negedge clk);
    chk("q32_drained", q32.size(), 0);
    chk("q64_drained", q64.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
